shared_datapath_arbiter: RTL and testbench
==========================================

Name: shared_datapath_arbiter

Overview:
Shares one iterative shift/accumulate datapath between NREQ requesters. It grants the datapath to one requester at a time, in round-robin order. For each job it clears the datapath, then enables its counter and register for exactly CYCLES clocks, then signals done to the granted requester. It carries its own iteration counter, so the datapath needs no terminal-count line.

Parameters:
NREQ, 2, number of requesters (2..8)
CYCLES, 5, datapath iterations per job (>=1)
CW, 3, iteration counter width; must satisfy 2^CW > CYCLES

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester job request, level, held until done seen
gnt  out  NREQ  one-hot grant; registered; 0 when no job owned
done  out  NREQ  one-hot completion; equals gnt while in DONE state
ready  out  1  high in IDLE only
busy  out  1  high in LOAD, RUN, DONE
dp_reset  out  1  datapath clear; high in IDLE and LOAD
dp_c_en  out  1  datapath counter enable; high in RUN only
dp_reg_en  out  1  datapath register enable; high in RUN only

Behaviour:
- All outputs are Moore outputs, decoded from registered state and gnt only. There are no combinational paths from req to any output.
- Reset (rst=0, async), effective immediately:
  - state=IDLE, gnt=0, done=0, cnt=0, ptr=0.
  - ready=1, dp_reset=1, busy=0, dp_c_en=0, dp_reg_en=0.
- Reset mid-job discards the job. No done is issued.
- States: IDLE, LOAD, RUN, DONE (2-bit encoding).
- IDLE:
  - If req != 0: select the first asserted req[i] scanning from index ptr upward, wrapping modulo NREQ. Set gnt <= onehot(i), cnt <= 0, go to LOAD.
  - Else stay in IDLE.
- LOAD (1 cycle):
  - dp_reset=1.
  - If req[g]=0 (g = granted index): abort, go to IDLE.
  - Else go to RUN.
- RUN:
  - dp_c_en=dp_reg_en=1; cnt increments each cycle.
  - When cnt==CYCLES-1, go to DONE. RUN lasts exactly CYCLES cycles.
  - If req[g]=0 on any RUN edge: abort, go to IDLE. The abort takes priority over the terminal count.
- DONE:
  - done=gnt.
  - Hold until req[g]=0, then go to IDLE.
  - Requesters must drop req after seeing done. Otherwise the block stays in DONE indefinitely, by design.
- On every exit to IDLE (normal or abort):
  - gnt <= 0.
  - ptr <= (g+1) mod NREQ.
- Latency: req asserted before edge k with the block in IDLE gives:
  - LOAD after edge k.
  - RUN after edges k+1..k+CYCLES.
  - DONE after edge k+CYCLES+1.
- Requests arriving while busy are ignored until IDLE, and gnt never changes mid-job. Requests from non-granted requesters never affect the current job.
- Simultaneous requests are resolved by ptr only. A requester that holds req continuously is served within NREQ jobs.
- Back-to-back jobs:
  - Minimum one IDLE cycle between jobs (ready=1 for at least one cycle).
  - The next grant is sampled in that IDLE cycle.
- Illegal state codes are not reachable. The default branch returns to IDLE with gnt=0.
- cnt saturating or wrapping is irrelevant, since cnt is reset on each LOAD.

Test Plan:
- Reset: drive rst=0 mid-RUN, asynchronously between edges -> outputs go immediately to gnt=00, done=00, ready=1, dp_reset=1, dp_c_en=0, busy=0. After release with req=00, the block stays in IDLE.
- Single job: req=01 before edge 10 ->
  - edge 10: gnt=01, dp_reset=1 (LOAD).
  - edges 11-15: dp_c_en=dp_reg_en=1 for exactly 5 cycles.
  - edge 16: done=01.
  - drop req at edge 20 -> IDLE after edge 20, gnt=00, ready=1.
- Fairness: req=11 held, each requester drops req one cycle after done and re-raises one cycle later -> grant sequence 01, 10, 01, 10. Each job shows exactly 5 dp_c_en cycles.
- Abort: req=01; drop req[0] on the 3rd RUN cycle -> IDLE at the next edge, dp_c_en=0, done never asserted. A following req=11 is granted 10 (ptr=1).
- Late request: req[1] rises during RUN of job 0 -> gnt stays 01 through DONE. After req[0] drops: one IDLE cycle, then gnt=10.
- Parameter sweep: CYCLES=1 and CYCLES=7 (CW=3), NREQ=3 -> RUN length equals CYCLES, and the round-robin order with req=111 is 001, 010, 100.

Source files
------------

// File: rtl/shared_datapath_arbiter.sv
// Round-robin arbiter that lends one iterative shift/accumulate datapath to NREQ
// requesters, sequencing clear, CYCLES enabled iterations and a done handshake.
module shared_datapath_arbiter #(
  parameter int NREQ   = 2,
  parameter int CYCLES = 5,
  parameter int CW     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            ready,
  output logic            busy,
  output logic            dp_reset,
  output logic            dp_c_en,
  output logic            dp_reg_en
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [NREQ-1:0] gnt_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [PW-1:0]   ptr, ptr_next, ptr_wrap;
  logic [PW-1:0]   sel_idx, hi_idx, gnt_idx;
  logic            sel_found, hi_found, req_g;

  // Lowest requester at or above ptr wins; otherwise the lowest requester overall.
  always_comb begin
    sel_found = |req;
    sel_idx   = '0;
    hi_found  = 1'b0;
    hi_idx    = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        sel_idx = PW'(j);
        if (j >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = PW'(j);
        end
      end
    end
    if (hi_found) sel_idx = hi_idx;
  end

  always_comb begin
    gnt_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt[j]) gnt_idx = PW'(j);
    end
  end

  assign req_g    = |(req & gnt);
  assign ptr_wrap = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
      cnt   <= cnt_next;
      ptr   <= ptr_next;
    end
  end

  // Losing the granted request aborts the job and outranks the terminal count.
  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    cnt_next   = cnt;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (sel_found) begin
          gnt_next   = NREQ'(1) << sel_idx;
          cnt_next   = '0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        cnt_next = '0;
        if (!req_g) begin
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = ptr_wrap;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        cnt_next = cnt + 1'b1;
        if (!req_g) begin
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = ptr_wrap;
        end else if (cnt == CW'(CYCLES - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!req_g) begin
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = ptr_wrap;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  assign done      = (state == DONE) ? gnt : '0;
  assign ready     = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dp_reset  = (state == IDLE) || (state == LOAD);
  assign dp_c_en   = (state == RUN);
  assign dp_reg_en = (state == RUN);

endmodule

// File: tb/tb_shared_datapath_arbiter.sv
// Checks three arbiter configurations against a job-level model that tracks
// owner, cycles since grant and round-robin pointer for each instance.
module tb_shared_datapath_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] reqv [3];
  logic [7:0] gntv [3];
  logic [7:0] donev [3];
  logic [4:0] flagv [3];

  logic [1:0] gnt0, done0;
  logic [2:0] gnt1, done1, gnt2, done2;
  logic       rdy0, bsy0, dpr0, cen0, ren0;
  logic       rdy1, bsy1, dpr1, cen1, ren1;
  logic       rdy2, bsy2, dpr2, cen2, ren2;

  shared_datapath_arbiter #(.NREQ(2), .CYCLES(5), .CW(3)) dut0 (
    .clk(clk), .rst(rst), .req(reqv[0][1:0]), .gnt(gnt0), .done(done0),
    .ready(rdy0), .busy(bsy0), .dp_reset(dpr0), .dp_c_en(cen0), .dp_reg_en(ren0));
  shared_datapath_arbiter #(.NREQ(3), .CYCLES(1), .CW(3)) dut1 (
    .clk(clk), .rst(rst), .req(reqv[1][2:0]), .gnt(gnt1), .done(done1),
    .ready(rdy1), .busy(bsy1), .dp_reset(dpr1), .dp_c_en(cen1), .dp_reg_en(ren1));
  shared_datapath_arbiter #(.NREQ(3), .CYCLES(7), .CW(3)) dut2 (
    .clk(clk), .rst(rst), .req(reqv[2][2:0]), .gnt(gnt2), .done(done2),
    .ready(rdy2), .busy(bsy2), .dp_reset(dpr2), .dp_c_en(cen2), .dp_reg_en(ren2));

  assign gntv[0]  = {6'b0, gnt0};
  assign gntv[1]  = {5'b0, gnt1};
  assign gntv[2]  = {5'b0, gnt2};
  assign donev[0] = {6'b0, done0};
  assign donev[1] = {5'b0, done1};
  assign donev[2] = {5'b0, done2};
  assign flagv[0] = {rdy0, bsy0, dpr0, cen0, ren0};
  assign flagv[1] = {rdy1, bsy1, dpr1, cen1, ren1};
  assign flagv[2] = {rdy2, bsy2, dpr2, cen2, ren2};

  int compared   = 0;
  int mismatched = 0;

  int nq [3] = '{2, 3, 3};
  int cy [3] = '{5, 1, 7};
  int own [3];
  int age [3];
  int mptr [3];

  task automatic modelReset();
    for (int d = 0; d < 3; d++) begin
      own[d]  = -1;
      age[d]  = 0;
      mptr[d] = 0;
    end
  endtask

  // age 0 is the clear cycle, ages 1..CYCLES are iterations, CYCLES+1 is done.
  task automatic modelStep();
    if (!rst) begin
      modelReset();
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (own[d] < 0) begin
          for (int k = 0; k < nq[d]; k++) begin
            int idx;
            idx = (mptr[d] + k) % nq[d];
            if (own[d] < 0 && reqv[d][idx]) begin
              own[d] = idx;
              age[d] = 0;
            end
          end
        end else if (!reqv[d][own[d]]) begin
          mptr[d] = (own[d] + 1) % nq[d];
          own[d]  = -1;
          age[d]  = 0;
        end else if (age[d] <= cy[d]) begin
          age[d]++;
        end
      end
    end
  endtask

  function automatic logic [7:0] expGnt(int d);
    return (own[d] < 0) ? 8'h00 : (8'h01 << own[d]);
  endfunction

  function automatic logic [7:0] expDone(int d);
    return (own[d] >= 0 && age[d] == cy[d] + 1) ? expGnt(d) : 8'h00;
  endfunction

  function automatic logic [4:0] expFlags(int d);
    logic inRun;
    if (own[d] < 0) return 5'b10100;
    inRun = (age[d] >= 1 && age[d] <= cy[d]);
    return {1'b0, 1'b1, (age[d] == 0), inRun, inRun};
  endfunction

  task automatic checkOutput();
    for (int d = 0; d < 3; d++) begin
      compared++;
      assert (gntv[d] === expGnt(d)) else begin
        mismatched++;
        $error("[TB] FAIL gnt dut%0d t=%0t got %h want %h", d, $time, gntv[d], expGnt(d));
      end
      compared++;
      assert (donev[d] === expDone(d)) else begin
        mismatched++;
        $error("[TB] FAIL done dut%0d t=%0t got %h want %h", d, $time, donev[d], expDone(d));
      end
      compared++;
      assert (flagv[d] === expFlags(d)) else begin
        mismatched++;
        $error("[TB] FAIL flags(rdy,bsy,dpr,cen,ren) dut%0d t=%0t got %b want %b",
               d, $time, flagv[d], expFlags(d));
      end
    end
  endtask

  // mode 0: no requests; 1: random with occasional aborts; 2: all held, drop after done.
  task automatic applyStimulus(int mode);
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < nq[d]; i++) begin
        if (mode == 0) begin
          reqv[d][i] = 1'b0;
        end else if (mode == 2) begin
          reqv[d][i] = !(own[d] == i && age[d] == cy[d] + 1);
        end else if (own[d] == i) begin
          if (age[d] == cy[d] + 1) reqv[d][i] = ($urandom_range(3) == 0);
          else reqv[d][i] = ($urandom_range(15) != 0);
        end else if ($urandom_range(3) == 0) begin
          reqv[d][i] = ~reqv[d][i];
        end
      end
    end
  endtask

  task automatic runCycles(int n, int mode);
    repeat (n) begin
      applyStimulus(mode);
      @(posedge clk);
      modelStep();
      #1;
      checkOutput();
    end
  endtask

  task automatic asyncReset();
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput();
    runCycles(2, 0);
    #3;
    rst = 1'b1;
    runCycles(4, 0);
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 3; d++) reqv[d] = 8'h00;
    modelReset();
    #2;
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b1;
    runCycles(2, 0);
    runCycles(4, 2);
    asyncReset();
    runCycles(80, 2);
    runCycles(400, 1);
    runCycles(3, 1);
    asyncReset();
    runCycles(60, 2);
    runCycles(400, 1);
    runCycles(20, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
